ccip_rd_tracker: RTL and testbench

Passive CCI-P monitor tapping the AFU read path (C0 Tx read requests, C0 Rx read responses), upstream of the transaction logger. Tracks outstanding reads by mdata tag and age-checks them. Emits protocol-error events over a valid/ready event port that the logger consumes as buffer messages. Also exposes running counters for end-of-sim statistics.

---
 rtl/ase_pkg.sv | 42 ++++
 rtl/ccip_rd_tracker_pkg.sv | 18 +
 rtl/ccip_rd_tracker_if.sv | 31 +++
 rtl/ccip_rd_evt_fifo.sv | 67 ++++++
 rtl/ccip_rd_tracker.sv | 144 ++++++++++++++
 tb/tb_ccip_rd_tracker.sv | 287 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/ase_pkg.sv
// Shared CCI-P types: C0 request/response headers and the read-tracker event encoding.
package ase_pkg;

  typedef struct packed {
    logic [1:0]  vc_sel;
    logic [1:0]  rsvd1;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic [5:0]  rsvd0;
    logic [41:0] address;
    logic [15:0] mdata;
  } TxHdr_t;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        rsvd1;
    logic        hit_miss;
    logic [1:0]  rsvd0;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } RxHdr_t;

  typedef enum logic [2:0] {
    RD_EVT_NONE         = 3'd0,
    RD_EVT_DUP_TAG      = 3'd1,
    RD_EVT_ORPHAN_RSP   = 3'd2,
    RD_EVT_TIMEOUT      = 3'd3,
    RD_EVT_ALMFULL_VIOL = 3'd4
  } rd_evt_e;

  // Event record at the default tracker widths (6-bit tag, 16-bit timestamp).
  localparam int RD_EVT_TAG_W = 6;
  localparam int RD_EVT_TS_W  = 16;

  typedef struct packed {
    rd_evt_e                 code;
    logic [RD_EVT_TAG_W-1:0] tag;
    logic [RD_EVT_TS_W-1:0]  ts;
  } rd_evt_t;

endpackage

// File: rtl/ccip_rd_tracker_pkg.sv
// Local constants for ccip_rd_tracker: event FIFO geometry and push-port ordering.
package ccip_rd_tracker_pkg;

  localparam int EVT_FIFO_DEPTH = 4;
  localparam int EVT_PORTS      = 4;

  // Push order into the event FIFO; lower index wins space first.
  localparam int PORT_ORPHAN  = 0;
  localparam int PORT_DUP     = 1;
  localparam int PORT_ALMFULL = 2;
  localparam int PORT_TIMEOUT = 3;

  // Width needed to count AlmFull cycles up to one beyond the slack.
  function automatic int alm_cnt_width(input int slack);
    return $clog2(slack + 2);
  endfunction

endpackage

// File: rtl/ccip_rd_tracker_if.sv
// C0 read-path tap plus the protocol-event port of ccip_rd_tracker.
interface ccip_rd_tracker_if
  import ase_pkg::*;
#(
  parameter int TAG_WIDTH = 6,
  parameter int TS_WIDTH  = 16
);
  TxHdr_t C0TxHdr;
  logic   C0TxRdValid;
  logic   C0TxAlmFull;
  RxHdr_t C0RxHdr;
  logic   C0RxRdValid;

  // evt_valid/evt_ready: an event transfers on each cycle both are high; while
  // evt_valid is high and evt_ready low, evt_code/evt_tag/evt_ts hold stable.
  logic                 evt_valid;
  logic                 evt_ready;
  logic [2:0]           evt_code;
  logic [TAG_WIDTH-1:0] evt_tag;
  logic [TS_WIDTH-1:0]  evt_ts;

  modport master (
    output C0TxHdr, C0TxRdValid, C0TxAlmFull, C0RxHdr, C0RxRdValid, evt_ready,
    input  evt_valid, evt_code, evt_tag, evt_ts
  );

  modport slave (
    input  C0TxHdr, C0TxRdValid, C0TxAlmFull, C0RxHdr, C0RxRdValid, evt_ready,
    output evt_valid, evt_code, evt_tag, evt_ts
  );
endinterface

// File: rtl/ccip_rd_evt_fifo.sv
// Small event FIFO: several ordered push ports per cycle, one pop, sticky drop flag.
module ccip_rd_evt_fifo #(
  parameter int W     = 8,
  parameter int NPUSH = 3,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NPUSH-1:0]          push,
  input  logic [NPUSH-1:0][W-1:0]   pushData,
  output logic                      outValid,
  input  logic                      outReady,
  output logic [W-1:0]              outData,
  output logic                      dropped
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]              mem [DEPTH];
  logic [PW-1:0]             rdPtr;
  logic [CW-1:0]             count;
  logic [CW-1:0]             space;
  logic [CW-1:0]             accepted;
  logic                      pop;
  logic                      anyDrop;
  logic [NPUSH-1:0]          wrEn;
  logic [NPUSH-1:0][PW-1:0]  wrIdx;

  assign outValid = (count != '0);
  assign outData  = mem[rdPtr];
  assign pop      = outValid && outReady;
  // A pop this cycle frees its slot for a push in the same cycle.
  assign space    = CW'(DEPTH) - count + CW'(pop);

  always_comb begin
    accepted = '0;
    anyDrop  = 1'b0;
    wrEn     = '0;
    wrIdx    = '0;
    for (int i = 0; i < NPUSH; i++) begin
      if (push[i]) begin
        if (accepted < space) begin
          wrEn[i]  = 1'b1;
          wrIdx[i] = rdPtr + count[PW-1:0] + accepted[PW-1:0];
          accepted = accepted + CW'(1);
        end else begin
          anyDrop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr   <= '0;
      count   <= '0;
      dropped <= 1'b0;
    end else begin
      if (pop) rdPtr <= rdPtr + PW'(1);
      count <= count + accepted - CW'(pop);
      if (anyDrop) dropped <= 1'b1;
      for (int i = 0; i < NPUSH; i++) begin
        if (wrEn[i]) mem[wrIdx[i]] <= pushData[i];
      end
    end
  end
endmodule

// File: rtl/ccip_rd_tracker.sv
// Passive C0 read tracker: tag table, age scanner, AlmFull check, event FIFO, statistics.
// Build option CCIP_RD_TRACKER_LATENCY_EN adds min/max response-latency tracking.
module ccip_rd_tracker
  import ase_pkg::*;
  import ccip_rd_tracker_pkg::*;
#(
  parameter int TAG_WIDTH      = 6,
  parameter int TS_WIDTH       = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int ALMFULL_SLACK  = 8,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 SoftReset,
  ccip_rd_tracker_if.slave     bus,
  output logic [TAG_WIDTH:0]   outstanding_cnt,
  output logic [TAG_WIDTH:0]   max_outstanding,
  output logic [CNT_WIDTH-1:0] total_rd_req,
  output logic [CNT_WIDTH-1:0] total_rd_rsp,
  output logic                 evt_overflow,
  output logic [TS_WIDTH-1:0]  min_latency,
  output logic [TS_WIDTH-1:0]  max_latency
);
  localparam int NTAGS = 1 << TAG_WIDTH;
  localparam int EW    = 3 + TAG_WIDTH + TS_WIDTH;
  localparam int OW    = TAG_WIDTH + 1;
  localparam int AW    = alm_cnt_width(ALMFULL_SLACK);

  logic [TS_WIDTH-1:0]  now;
  logic [NTAGS-1:0]     tabValid;
  logic [TS_WIDTH-1:0]  tabTs [NTAGS];
  logic [TAG_WIDTH-1:0] scanPtr;
  logic [AW-1:0]        almCnt;

  logic [TAG_WIDTH-1:0] reqTag, rspTag;
  logic                 reqV, rspV;
  logic                 rspHit, orphan, dup, newReq, almViol, timeout, scanSkip;
  logic [TS_WIDTH-1:0]  scanAge;
  logic [OW-1:0]        outNext;

  logic [EVT_PORTS-1:0]         pushVec;
  logic [EVT_PORTS-1:0][EW-1:0] pushData;
  logic [EW-1:0]                fifoOut;

  logic unusedHdrBits;
  assign unusedHdrBits = ^{bus.C0TxHdr, bus.C0RxHdr};

  assign reqTag = bus.C0TxHdr.mdata[TAG_WIDTH-1:0];
  assign rspTag = bus.C0RxHdr.mdata[TAG_WIDTH-1:0];
  assign reqV   = bus.C0TxRdValid;
  assign rspV   = bus.C0RxRdValid;

  // Response is resolved before request, so a same-tag pair never looks like a duplicate.
  assign rspHit  = rspV && tabValid[rspTag];
  assign orphan  = rspV && !tabValid[rspTag];
  assign dup     = reqV && tabValid[reqTag] && !(rspV && (rspTag == reqTag));
  assign newReq  = reqV && !dup;
  assign almViol = reqV && (almCnt > AW'(ALMFULL_SLACK));

  assign scanAge  = now - tabTs[scanPtr];
  assign scanSkip = (reqV && (reqTag == scanPtr)) || (rspV && (rspTag == scanPtr));
  assign timeout  = !scanSkip && tabValid[scanPtr] && (scanAge >= TS_WIDTH'(TIMEOUT_CYCLES));

  assign outNext = outstanding_cnt + OW'(newReq) - OW'(rspHit) - OW'(timeout);

  always_comb begin
    pushVec                = '0;
    pushData               = '0;
    pushVec[PORT_ORPHAN]   = orphan;
    pushData[PORT_ORPHAN]  = {RD_EVT_ORPHAN_RSP, rspTag, now};
    pushVec[PORT_DUP]      = dup;
    pushData[PORT_DUP]     = {RD_EVT_DUP_TAG, reqTag, now};
    pushVec[PORT_ALMFULL]  = almViol;
    pushData[PORT_ALMFULL] = {RD_EVT_ALMFULL_VIOL, {TAG_WIDTH{1'b0}}, now};
    pushVec[PORT_TIMEOUT]  = timeout;
    pushData[PORT_TIMEOUT] = {RD_EVT_TIMEOUT, scanPtr, now};
  end

  always_ff @(posedge clk) begin
    if (SoftReset) begin
      now             <= '0;
      tabValid        <= '0;
      scanPtr         <= '0;
      almCnt          <= '0;
      outstanding_cnt <= '0;
      max_outstanding <= '0;
      total_rd_req    <= '0;
      total_rd_rsp    <= '0;
    end else begin
      now     <= now + TS_WIDTH'(1);
      scanPtr <= scanPtr + TAG_WIDTH'(1);
      // The scanner never targets a tag touched this cycle, so these writes never collide.
      if (timeout) tabValid[scanPtr] <= 1'b0;
      if (rspV) tabValid[rspTag] <= 1'b0;
      if (reqV) begin
        tabValid[reqTag] <= 1'b1;
        tabTs[reqTag]    <= now;
      end
      if (!bus.C0TxAlmFull) almCnt <= '0;
      else if (almCnt <= AW'(ALMFULL_SLACK)) almCnt <= almCnt + AW'(1);
      outstanding_cnt <= outNext;
      if (outNext > max_outstanding) max_outstanding <= outNext;
      total_rd_req <= total_rd_req + CNT_WIDTH'(reqV);
      total_rd_rsp <= total_rd_rsp + CNT_WIDTH'(rspV);
    end
  end

  ccip_rd_evt_fifo #(
    .W     (EW),
    .NPUSH (EVT_PORTS),
    .DEPTH (EVT_FIFO_DEPTH)
  ) u_evt_fifo (
    .clk      (clk),
    .rst      (SoftReset),
    .push     (pushVec),
    .pushData (pushData),
    .outValid (bus.evt_valid),
    .outReady (bus.evt_ready),
    .outData  (fifoOut),
    .dropped  (evt_overflow)
  );

  assign bus.evt_code = fifoOut[EW-1 -: 3];
  assign bus.evt_tag  = fifoOut[TS_WIDTH +: TAG_WIDTH];
  assign bus.evt_ts   = fifoOut[TS_WIDTH-1:0];

`ifdef CCIP_RD_TRACKER_LATENCY_EN
  logic [TS_WIDTH-1:0] rspLat;
  assign rspLat = now - tabTs[rspTag];

  always_ff @(posedge clk) begin
    if (SoftReset) begin
      min_latency <= '1;
      max_latency <= '0;
    end else if (rspHit) begin
      if (rspLat < min_latency) min_latency <= rspLat;
      if (rspLat > max_latency) max_latency <= rspLat;
    end
  end
`else
  assign min_latency = '1;
  assign max_latency = '0;
`endif
endmodule

// File: tb/tb_ccip_rd_tracker.sv
// Directed bench for ccip_rd_tracker: a per-cycle vector table plus hand-written multi-cycle cases.
module tb_ccip_rd_tracker;
  import ase_pkg::*;

  localparam int TAG_WIDTH      = 6;
  localparam int TS_WIDTH       = 16;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int ALMFULL_SLACK  = 8;
  localparam int CNT_WIDTH      = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic SoftReset;
  always #5 clk = ~clk;

  ccip_rd_tracker_if #(.TAG_WIDTH(TAG_WIDTH), .TS_WIDTH(TS_WIDTH)) bus ();

  logic [TAG_WIDTH:0]   outstanding_cnt, max_outstanding;
  logic [CNT_WIDTH-1:0] total_rd_req, total_rd_rsp;
  logic                 evt_overflow;
  logic [TS_WIDTH-1:0]  min_latency, max_latency;

  ccip_rd_tracker #(
    .TAG_WIDTH      (TAG_WIDTH),
    .TS_WIDTH       (TS_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .ALMFULL_SLACK  (ALMFULL_SLACK),
    .CNT_WIDTH      (CNT_WIDTH)
  ) dut (
    .clk             (clk),
    .SoftReset       (SoftReset),
    .bus             (bus),
    .outstanding_cnt (outstanding_cnt),
    .max_outstanding (max_outstanding),
    .total_rd_req    (total_rd_req),
    .total_rd_rsp    (total_rd_rsp),
    .evt_overflow    (evt_overflow),
    .min_latency     (min_latency),
    .max_latency     (max_latency)
  );

  // Cycle number as seen by the design's timestamp: zero at reset, +1 per clock.
  logic [TS_WIDTH-1:0] cyc;
  always @(posedge clk) begin
    if (SoftReset) cyc <= '0;
    else cyc <= cyc + 1'b1;
  end

  int n_vec  = 0;
  int n_miss = 0;

`ifdef CCIP_RD_TRACKER_LATENCY_EN
  localparam logic [TS_WIDTH-1:0] EXP_MIN_LAT = 16'd30;
  localparam logic [TS_WIDTH-1:0] EXP_MAX_LAT = 16'd30;
`else
  localparam logic [TS_WIDTH-1:0] EXP_MIN_LAT = 16'hFFFF;
  localparam logic [TS_WIDTH-1:0] EXP_MAX_LAT = 16'h0000;
`endif

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [TAG_WIDTH-1:0] tag);
    bus.C0TxHdr       = '0;
    bus.C0TxHdr.mdata = {10'h2A5, tag};
    bus.C0TxRdValid   = 1'b1;
  endtask

  task automatic set_rsp(input logic [TAG_WIDTH-1:0] tag);
    bus.C0RxHdr       = '0;
    bus.C0RxHdr.mdata = {10'h15A, tag};
    bus.C0RxRdValid   = 1'b1;
  endtask

  task automatic clear_bus();
    bus.C0TxRdValid = 1'b0;
    bus.C0RxRdValid = 1'b0;
  endtask

  task automatic do_reset();
    SoftReset = 1'b1;
    clear_bus();
    bus.C0TxAlmFull = 1'b0;
    repeat (3) step();
    SoftReset = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_evt_valid"},   32'(bus.evt_valid), 32'd0);
    check({pfx, "_outstanding"}, 32'(outstanding_cnt), 32'd0);
    check({pfx, "_max_out"},     32'(max_outstanding), 32'd0);
    check({pfx, "_total_req"},   total_rd_req, 32'd0);
    check({pfx, "_total_rsp"},   total_rd_rsp, 32'd0);
    check({pfx, "_overflow"},    32'(evt_overflow), 32'd0);
    check({pfx, "_min_lat"},     32'(min_latency), 32'hFFFF);
    check({pfx, "_max_lat"},     32'(max_latency), 32'd0);
  endtask

  typedef struct {
    logic                 req_v;
    logic [TAG_WIDTH-1:0] req_tag;
    logic                 rsp_v;
    logic [TAG_WIDTH-1:0] rsp_tag;
    logic                 exp_valid;
    logic [2:0]           exp_code;
    logic [TAG_WIDTH-1:0] exp_tag;
    logic [TAG_WIDTH:0]   exp_out;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [TS_WIDTH-1:0] t0, age;
    logic                found;

    // One record per cycle; expectations are the event at the FIFO head and
    // outstanding_cnt just after that cycle's clock edge (evt_ready held high).
    vecs[0]  = '{1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 3'd0, 6'd0,  7'd0};
    vecs[1]  = '{1'b1, 6'd3,  1'b0, 6'd0,  1'b0, 3'd0, 6'd0,  7'd1};
    vecs[2]  = '{1'b1, 6'd3,  1'b0, 6'd0,  1'b1, 3'd1, 6'd3,  7'd1};
    vecs[3]  = '{1'b0, 6'd0,  1'b0, 6'd0,  1'b0, 3'd0, 6'd0,  7'd1};
    vecs[4]  = '{1'b0, 6'd0,  1'b1, 6'd3,  1'b0, 3'd0, 6'd0,  7'd0};
    vecs[5]  = '{1'b0, 6'd0,  1'b1, 6'd9,  1'b1, 3'd2, 6'd9,  7'd0};
    vecs[6]  = '{1'b1, 6'd12, 1'b1, 6'd12, 1'b1, 3'd2, 6'd12, 7'd1};
    vecs[7]  = '{1'b1, 6'd12, 1'b1, 6'd12, 1'b0, 3'd0, 6'd0,  7'd1};
    vecs[8]  = '{1'b0, 6'd0,  1'b1, 6'd12, 1'b0, 3'd0, 6'd0,  7'd0};
    vecs[9]  = '{1'b1, 6'd20, 1'b0, 6'd0,  1'b0, 3'd0, 6'd0,  7'd1};
    vecs[10] = '{1'b1, 6'd20, 1'b1, 6'd21, 1'b1, 3'd2, 6'd21, 7'd1};
    vecs[11] = '{1'b0, 6'd0,  1'b0, 6'd0,  1'b1, 3'd1, 6'd20, 7'd1};
    vecs[12] = '{1'b0, 6'd0,  1'b1, 6'd20, 1'b0, 3'd0, 6'd0,  7'd0};

    bus.C0TxHdr     = '0;
    bus.C0RxHdr     = '0;
    bus.C0TxRdValid = 1'b0;
    bus.C0RxRdValid = 1'b0;
    bus.C0TxAlmFull = 1'b0;
    bus.evt_ready   = 1'b1;
    do_reset();
    check_reset_state("reset");

    // ---------------- table vectors ----------------
    for (int i = 0; i < 13; i++) begin
      clear_bus();
      if (vecs[i].req_v) set_req(vecs[i].req_tag);
      if (vecs[i].rsp_v) set_rsp(vecs[i].rsp_tag);
      step();
      check($sformatf("vec%0d_evt_valid", i), 32'(bus.evt_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_outstanding", i), 32'(outstanding_cnt), 32'(vecs[i].exp_out));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_evt_code", i), 32'(bus.evt_code), 32'(vecs[i].exp_code));
        check($sformatf("vec%0d_evt_tag", i), 32'(bus.evt_tag), 32'(vecs[i].exp_tag));
      end
    end
    clear_bus();
    step();
    check("tbl_total_req", total_rd_req, 32'd6);
    check("tbl_total_rsp", total_rd_rsp, 32'd7);
    check("tbl_max_out",   32'(max_outstanding), 32'd1);
    check("tbl_overflow",  32'(evt_overflow), 32'd0);
    check("tbl_drained",   32'(bus.evt_valid), 32'd0);

    // ---------------- request/response latency ----------------
    do_reset();
    for (int k = 0; k < 50 && cyc != 16'd10; k++) step();
    check("lat_req_cycle", 32'(cyc), 32'd10);
    set_req(6'd5);
    step();
    clear_bus();
    check("lat_out_after_req", 32'(outstanding_cnt), 32'd1);
    check("lat_total_req", total_rd_req, 32'd1);
    for (int k = 0; k < 50 && cyc != 16'd40; k++) step();
    check("lat_rsp_cycle", 32'(cyc), 32'd40);
    set_rsp(6'd5);
    step();
    clear_bus();
    check("lat_out_after_rsp", 32'(outstanding_cnt), 32'd0);
    check("lat_total_rsp", total_rd_rsp, 32'd1);
    check("lat_no_evt", 32'(bus.evt_valid), 32'd0);
    check("lat_min", 32'(min_latency), 32'(EXP_MIN_LAT));
    check("lat_max", 32'(max_latency), 32'(EXP_MAX_LAT));

    // ---------------- timeout then late response ----------------
    set_req(6'd7);
    t0 = cyc;
    step();
    clear_bus();
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (bus.evt_valid) found = 1'b1;
      else step();
    end
    check("to_seen", 32'(found), 32'd1);
    age = bus.evt_ts - t0;
    check("to_code", 32'(bus.evt_code), 32'd3);
    check("to_tag", 32'(bus.evt_tag), 32'd7);
    check("to_age_in_window", 32'(age >= 16'd100 && age <= 16'd164), 32'd1);
    check("to_ts_is_detect_cycle", 32'(bus.evt_ts), 32'(cyc - 16'd1));
    check("to_outstanding", 32'(outstanding_cnt), 32'd0);
    step();
    set_rsp(6'd7);
    t0 = cyc;
    step();
    clear_bus();
    check("late_rsp_valid", 32'(bus.evt_valid), 32'd1);
    check("late_rsp_code", 32'(bus.evt_code), 32'd2);
    check("late_rsp_tag", 32'(bus.evt_tag), 32'd7);
    check("late_rsp_ts", 32'(bus.evt_ts), 32'(t0));
    step();

    // ---------------- AlmFull slack ----------------
    for (int c = 1; c <= 14; c++) begin
      bus.C0TxAlmFull = (c <= 12);
      clear_bus();
      if (c == 5) set_req(6'd40);
      if (c == 10) set_req(6'd41);
      t0 = cyc;
      step();
      if (c == 5) check("alm_early_no_evt", 32'(bus.evt_valid), 32'd0);
      if (c == 10) begin
        check("alm_viol_valid", 32'(bus.evt_valid), 32'd1);
        check("alm_viol_code", 32'(bus.evt_code), 32'd4);
        check("alm_viol_tag", 32'(bus.evt_tag), 32'd0);
        check("alm_viol_ts", 32'(bus.evt_ts), 32'(t0));
      end
    end
    clear_bus();
    check("alm_reqs_tracked", 32'(outstanding_cnt), 32'd2);
    set_rsp(6'd40);
    step();
    set_rsp(6'd41);
    step();
    clear_bus();
    step();
    check("alm_cleanup_out", 32'(outstanding_cnt), 32'd0);
    check("alm_cleanup_no_evt", 32'(bus.evt_valid), 32'd0);

    // ---------------- FIFO overflow with consumer stalled ----------------
    bus.evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      clear_bus();
      set_rsp(6'(50 + i));
      step();
      check($sformatf("ovf_hold_tag_%0d", i), 32'(bus.evt_tag), 32'd50);
    end
    clear_bus();
    step();
    check("ovf_sticky", 32'(evt_overflow), 32'd1);
    check("ovf_valid_stalled", 32'(bus.evt_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_pop%0d_valid", i), 32'(bus.evt_valid), 32'd1);
      check($sformatf("ovf_pop%0d_code", i), 32'(bus.evt_code), 32'd2);
      check($sformatf("ovf_pop%0d_tag", i), 32'(bus.evt_tag), 32'(50 + i));
      bus.evt_ready = 1'b1;
      step();
    end
    check("ovf_empty", 32'(bus.evt_valid), 32'd0);
    check("ovf_still_sticky", 32'(evt_overflow), 32'd1);

    // ---------------- reset mid-operation ----------------
    bus.evt_ready = 1'b0;
    set_rsp(6'd60);
    set_req(6'd61);
    step();
    clear_bus();
    check("mid_pending_evt", 32'(bus.evt_valid), 32'd1);
    do_reset();
    check_reset_state("midrst");
    bus.evt_ready = 1'b1;
    repeat (3) step();
    check("midrst_quiet", 32'(bus.evt_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
